// File: rtl/counter_pkg.sv
// Shared definitions for the up and down counters.
//   STATE_RUN / STATE_EXPIRED : 1-bit state encodings
//   state_e                   : FSM state type built on those encodings
//   counter_width()           : counter width for a given maximum value
//   clamp_value()             : min(value, max_value) on 32-bit unsigned operands
package counter_pkg;

    localparam logic STATE_RUN     = 1'b0;
    localparam logic STATE_EXPIRED = 1'b1;

    typedef enum logic {
        StRun     = STATE_RUN,
        StExpired = STATE_EXPIRED
    } state_e;

    // Width needed to hold 0..max_value; shared so both counters agree.
    function automatic int unsigned counter_width(input int unsigned max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    // Done on 32-bit operands so a narrow port against a full-range maximum
    // does not turn into a constant comparison.
    function automatic int unsigned clamp_value(input int unsigned value,
                                                input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-strobe generator: divides enabled cycles by PRESCALE.
// Ports:
//   clk_i      clock
//   s_rst_n_i  synchronous active-low reset (clears the phase counter)
//   enable_i   advance the phase counter this cycle
//   clear_i    force the phase counter back to 0 (has priority over enable_i)
//   step_o     high on an enabled cycle whose phase is PRESCALE-1
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk_i,
    input  logic s_rst_n_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic step_o
);

    localparam int unsigned CW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last   = (cnt_q == CW'(PRESCALE - 1));
    assign step_o = enable_i && !clear_i && last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter / timer with terminal-count pulse and optional auto-reload.
// Optional build macro: DOWN_COUNTER_PRESCALER_EN (one step every PRESCALE enabled cycles).
// Ports:
//   clk_i          clock, all state on rising edge
//   s_rst_n_i      synchronous active-low reset
//   enable_i       count enable (one step per enabled RUN cycle)
//   load_i         load strobe (priority over counting)
//   load_value_i   value to load, clamped to MAX_VALUE
//   auto_reload_i  1 = reload at terminal count, 0 = one-shot
//   value_o        current count (registered)
//   zero_o         value_o == 0
//   tc_pulse_o     registered one-cycle terminal-count pulse
//   busy_o         high while in RUN
module down_counter
    import counter_pkg::*;
#(
    parameter int unsigned MAX_VALUE = 255,
    parameter int unsigned PRESCALE  = 4,
    localparam int unsigned WIDTH    = counter_width(MAX_VALUE)
) (
    input  logic             clk_i,
    input  logic             s_rst_n_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] value_o,
    output logic             zero_o,
    output logic             tc_pulse_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

    if (PRESCALE < 2) begin : g_prescale_check
        $error("down_counter: PRESCALE must be at least 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_clamped;
    logic             run_enable;
    logic             step;

    assign load_clamped = WIDTH'(clamp_value(32'(load_value_i), MAX_VALUE));

    // A load cycle never counts, so it must not advance the prescaler either.
    assign run_enable = enable_i && (state_q == StRun) && !load_i;

`ifdef DOWN_COUNTER_PRESCALER_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i     (clk_i),
        .s_rst_n_i (s_rst_n_i),
        .enable_i  (run_enable),
        .clear_i   (load_i),
        .step_o    (step)
    );
`else
    assign step = run_enable;
`endif

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load_i) begin
            value_d  = load_clamped;
            reload_d = load_clamped;
            state_d  = StRun;
        end else if (step) begin
            if (value_q == '0) begin
                tc_d = 1'b1;
                if (auto_reload_i) begin
                    value_d = reload_q;
                end else begin
                    state_d = StExpired;
                end
            end else begin
                value_d = value_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state_q  <= StRun;
            value_q  <= MaxVal;
            reload_q <= MaxVal;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign value_o    = value_q;
    assign zero_o     = (value_q == '0);
    assign tc_pulse_o = tc_q;
    assign busy_o     = (state_q == StRun);

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable down counter/timer. The decrementing counterpart of the team's up counter.
- Counts from a loaded value toward zero on each enabled cycle.
- Flags terminal count with a one-cycle pulse.
- Either reloads automatically or stops and waits for a new load.
- Used as a timeout/interval source beside the up counter in control blocks.

Parameters:
MAX_VALUE, 255, largest count value; counter width WIDTH = $clog2(MAX_VALUE + 1).
PRESCALE, 4, enabled cycles per decrement. Only used when DOWN_COUNTER_PRESCALER_EN is defined; legal range ≥ 2.

Ports:
clk_i  input  1  single clock; all state updates on rising edge
s_rst_n_i  input  1  synchronous active-low reset
enable_i  input  1  count enable; one decrement step per enabled cycle in RUN
load_i  input  1  load strobe; load_value_i into count and reload register
load_value_i  input  WIDTH  value to load; clamped to MAX_VALUE
auto_reload_i  input  1  1 = reload at terminal count, 0 = one-shot
value_o  output  WIDTH  current count (registered)
zero_o  output  1  value_o == 0 (combinational from count register)
tc_pulse_o  output  1  registered one-cycle terminal-count pulse
busy_o  output  1  high while state is RUN

Behaviour:
- Reset (s_rst_n_i low at a rising edge): applied regardless of every other input, including mid-count.
  - Registers: value_q = MAX_VALUE, reload_q = MAX_VALUE, state = RUN.
  - Outputs: value_o = MAX_VALUE, tc_pulse_o = 0, zero_o = 0, busy_o = 1.
- States are RUN and EXPIRED. Per-cycle priority is reset > load > count.
- Load (load_i = 1): in either state, on the next edge:
  - value_q = reload_q = min(load_value_i, MAX_VALUE);
  - state = RUN, tc_pulse_o = 0;
  - enable_i that cycle is ignored, so there is no decrement that cycle.
- RUN, enable_i = 1, value_q != 0: value_q = value_q - 1 on the next edge.
- RUN, enable_i = 1, value_q == 0 (terminal count): tc_pulse_o = 1 for exactly the next cycle. Then:
  - auto_reload_i = 1: value_q = reload_q, stay in RUN. Period is reload_q + 1 enabled cycles.
  - auto_reload_i = 0: value_q holds 0, state goes to EXPIRED.
- RUN, enable_i = 0: hold value_q, tc_pulse_o = 0.
- EXPIRED: enable_i is ignored, value_o = 0, zero_o = 1, busy_o = 0. Only load or reset leaves this state.
- Boundary cases:
  - Load of 0: value 0 in RUN; the next enabled cycle is terminal count.
  - Load equal to or above MAX_VALUE: value = MAX_VALUE.
  - Load in the same cycle as a terminal-count condition: load wins, no tc pulse.
  - auto_reload_i is sampled only at terminal count.
  - Arithmetic is unsigned WIDTH bits; the decrement never underflows because zero is handled explicitly.
- Latency: every output change is visible one clock after the causing input edge, except zero_o, which follows value_q combinationally.

Optional Feature:
Macro DOWN_COUNTER_PRESCALER_EN.
- Defined:
  - An internal prescale counter (0..PRESCALE-1) advances on each enabled RUN cycle.
  - A decrement or terminal-count step happens only when the prescale counter is PRESCALE-1; the prescale counter then wraps to 0.
  - Load and reset clear the prescale counter to 0.
  - Ports are unchanged.
- Not defined: each enabled RUN cycle is a step. PRESCALE is unused and no prescale logic exists.

Decomposition:
- Shared package counter_pkg:
  - state encoding localparams STATE_RUN and STATE_EXPIRED (1-bit);
  - a width helper function so that WIDTH = clog2(MAX_VALUE + 1) is computed identically in the up and down counters.
- One natural sub-module: counter_prescaler, which produces a step-strobe from enable and clear. It is instantiated only under DOWN_COUNTER_PRESCALER_EN.
- The FSM and datapath stay in down_counter.

Test Plan (MAX_VALUE = 255, CLOCK_PERIOD 100 ns, macro undefined unless stated):
- Reset then enable = 1 for 256 cycles, no load:
  - value_o = 255, 254, … 0;
  - tc_pulse_o high on the 257th edge;
  - one-shot: busy_o = 0, value_o stays 0 for 10 further cycles.
- Load 5, auto_reload_i = 1, enable = 1 for 18 cycles:
  - value sequence 5,4,3,2,1,0,5,4,…;
  - tc_pulse_o exactly every 6 cycles, 3 pulses total, busy_o always 1.
- From EXPIRED, load 300:
  - value_o = 255 (clamped), busy_o = 1 next cycle;
  - load 0 with enable = 1: tc_pulse_o on the second edge after load.
- Count at value 0 in RUN with load_i = 1 (load_value 7) in the same cycle: value_o = 7, tc_pulse_o stays 0.
- Reset pulse while value_o = 100 and auto_reload_i = 1: value_o = 255, tc_pulse_o = 0, busy_o = 1 on the following edge.
- DOWN_COUNTER_PRESCALER_EN, PRESCALE = 4, load 2, enable = 1:
  - value changes only every 4th enabled cycle (2,2,2,2,1,1,1,1,0,…);
  - tc_pulse_o after 12 enabled cycles;
  - an enable gap of 3 cycles stretches the timing by 3.
